// File: rtl/touch_key_pkg.sv
// touch_key_pkg: decoder FSM state encoding, vending key codes and a compile-time max helper
package touch_key_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0] KEY_CONFIRM = 4'd14;
  localparam logic [3:0] KEY_CANCEL = 4'd15;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/touch_key_hitmap.sv
// touch_key_hitmap: combinational (i_x, i_y) -> o_hit and o_code = row*KEY_COLS+col, via 17-bit comparator chains
module touch_key_hitmap #(
  parameter logic [15:0] KEY_X0 = 16'd80,
  parameter logic [15:0] KEY_Y0 = 16'd120,
  parameter logic [15:0] KEY_W = 16'd160,
  parameter logic [15:0] KEY_H = 16'd80,
  parameter int KEY_COLS = 4,
  parameter int KEY_ROWS = 4
) (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic        o_hit,
  output logic [3:0]  o_code
);
  logic [16:0] w_x, w_y;
  logic [1:0] w_col, w_row;
  assign w_x = {1'b0, i_x};
  assign w_y = {1'b0, i_y};
  assign o_hit = w_x >= 17'(KEY_X0) && w_x < 17'(KEY_X0) + 17'(KEY_COLS) * 17'(KEY_W) &&
                 w_y >= 17'(KEY_Y0) && w_y < 17'(KEY_Y0) + 17'(KEY_ROWS) * 17'(KEY_H);
  always_comb begin
    w_col = '0;
    w_row = '0;
    for (int n = 1; n < KEY_COLS; n++)
      if (w_x >= 17'(KEY_X0) + 17'(n) * 17'(KEY_W)) w_col = w_col + 2'd1;
    for (int n = 1; n < KEY_ROWS; n++)
      if (w_y >= 17'(KEY_Y0) + 17'(n) * 17'(KEY_H)) w_row = w_row + 2'd1;
  end
  assign o_code = 4'(int'(w_row) * KEY_COLS + int'(w_col));
endmodule

// File: rtl/touch_key_decoder.sv
// touch_key_decoder: touch_valid/data{X,Y} -> debounced single-shot key_valid pulse, key_code, key_held
module touch_key_decoder
  import touch_key_pkg::*;
#(
  parameter logic [15:0] KEY_X0 = 16'd80,
  parameter logic [15:0] KEY_Y0 = 16'd120,
  parameter logic [15:0] KEY_W = 16'd160,
  parameter logic [15:0] KEY_H = 16'd80,
  parameter int KEY_COLS = 4,
  parameter int KEY_ROWS = 4,
  parameter int STABLE_CYC = 500000,
  parameter int RELEASE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        touch_valid,
  input  logic [31:0] data,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held
);
  localparam int CMAX = max2(STABLE_CYC, RELEASE_CYC);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(CMAX);
  localparam logic [CW-1:0] C_ST = CW'(STABLE_CYC);
  localparam logic [CW-1:0] C_RL = CW'(RELEASE_CYC);
  state_t r_state, w_state;
  logic r_tv, r_fire, w_fire, w_hit;
  logic [15:0] r_x, r_y;
  logic [3:0] r_cand, w_cand, r_code, w_code;
  logic [CW-1:0] r_cnt, w_cnt, w_inc;
  touch_key_hitmap #(
    .KEY_X0(KEY_X0), .KEY_Y0(KEY_Y0), .KEY_W(KEY_W), .KEY_H(KEY_H),
    .KEY_COLS(KEY_COLS), .KEY_ROWS(KEY_ROWS)
  ) u_hitmap (
    .i_x(r_x),
    .i_y(r_y),
    .o_hit(w_hit),
    .o_code(w_code)
  );
  assign w_inc = r_cnt == C_MAX ? r_cnt : r_cnt + CW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tv <= 1'b0;
      r_x <= '0;
      r_y <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_cand <= '0;
      r_fire <= 1'b0;
      r_code <= '0;
    end else begin
      r_tv <= touch_valid;
      r_x <= data[31:16];
      r_y <= data[15:0];
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_cand <= w_cand;
      r_fire <= w_fire;
      if (w_fire) r_code <= w_cand;
    end
  end
  // a count reaching its threshold is resolved in the same cycle it is formed, so the
  // pulse/release lands exactly STABLE_CYC/RELEASE_CYC samples after the first one
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_cand = r_cand;
    w_fire = 1'b0;
    case (r_state)
      IDLE:
        if (r_tv && w_hit) begin
          w_cand = w_code;
          w_cnt = CW'(1);
          w_state = DEBOUNCE;
        end
      DEBOUNCE:
        if (!(r_tv && w_hit)) begin
          w_cnt = '0;
          w_state = IDLE;
        end else if (w_code != r_cand) begin
          w_cand = w_code;
          w_cnt = CW'(1);
        end else w_cnt = w_inc;
      PRESSED:
        if (!r_tv) begin
          w_cnt = CW'(1);
          w_state = RELEASE;
        end
      default:
        if (r_tv) begin
          w_cnt = '0;
          w_state = PRESSED;
        end else w_cnt = w_inc;
    endcase
    if (w_state == DEBOUNCE && w_cnt >= C_ST) begin
      w_fire = 1'b1;
      w_cnt = '0;
      w_state = PRESSED;
    end
    if (w_state == RELEASE && w_cnt >= C_RL) begin
      w_cnt = '0;
      w_state = IDLE;
    end
  end
  always_comb begin
    key_valid = r_fire;
    key_code = r_code;
    key_held = r_state == PRESSED || r_state == RELEASE;
  end
endmodule
